// File: rtl/instr_sequencer_pkg.sv
// Shared CPU definitions: sequencer state encoding, default widths and opcode constants.
package instr_sequencer_pkg;

    localparam int unsigned PC_WIDTH_DEF   = 8;
    localparam int unsigned DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC
    } seq_state_e;

    // Opcode lives in the top nibble of the instruction word; low byte is the literal.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_GOTO = 4'h2;
    localparam logic [3:0] OP_BRA  = 4'h3;

endpackage

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch / decode / execute control with program counter.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned PC_WIDTH          = PC_WIDTH_DEF,
    parameter int unsigned PROGRAM_DataWidth = DATA_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         run,
    output logic                         imem_req,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic                         imem_ack,
    input  logic [PROGRAM_DataWidth-1:0] imem_data,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    input  logic                         dec_wr_en,
    input  logic                         dec_stat_wr_en,
    input  logic                         dec_cnt_wr_en,
    input  logic                         dec_add_offset,
    input  logic [PC_WIDTH-1:0]          dec_literal_adr,
    output logic                         rf_wr_en,
    output logic                         stat_wr_en,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         busy,
    output logic                         retired
);

    seq_state_e                   state_q;
    logic [PC_WIDTH-1:0]          pc_q;
    logic [PC_WIDTH-1:0]          pc_d;
    logic [PROGRAM_DataWidth-1:0] instr_q;
    logic                         req_q;
    logic                         rf_wr_q;
    logic                         stat_wr_q;
    logic                         retired_q;
    logic                         busy_q;

    // Next program counter: sequential, absolute jump, or pc-relative branch (wraps naturally).
    always_comb begin
        pc_d = pc_q + PC_WIDTH'(1);
        if (dec_cnt_wr_en) begin
            if (dec_add_offset) begin
                pc_d = pc_q + dec_literal_adr;
            end else begin
                pc_d = dec_literal_adr;
            end
        end
    end

    // Sequencer FSM with registered control outputs.
    // The decoder is combinational on the instruction register and has settled by the
    // end of DECODE, so the EXEC strobes are captured on the DECODE->EXEC edge and are
    // therefore high for exactly the EXEC cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            req_q     <= 1'b0;
            rf_wr_q   <= 1'b0;
            stat_wr_q <= 1'b0;
            retired_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_data;
                        req_q   <= 1'b0;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_q   <= ST_EXEC;
                    rf_wr_q   <= dec_wr_en;
                    stat_wr_q <= dec_stat_wr_en;
                    retired_q <= 1'b1;
                end
                ST_EXEC: begin
                    rf_wr_q   <= 1'b0;
                    stat_wr_q <= 1'b0;
                    retired_q <= 1'b0;
                    pc_q      <= pc_d;
                    if (run) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign rf_wr_en    = rf_wr_q;
    assign stat_wr_en  = stat_wr_q;
    assign retired     = retired_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: instruction-level reference model plus directed program.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instruction;
    logic        dec_wr_en, dec_stat_wr_en, dec_cnt_wr_en, dec_add_offset;
    logic [7:0]  dec_literal_adr;
    logic        rf_wr_en, stat_wr_en, busy, retired;
    logic [7:0]  pc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_delay = 0;
    logic spurious = 1'b0;
    logic [15:0] imem [256];

    instr_sequencer #(.PC_WIDTH(8), .PROGRAM_DataWidth(16)) dut (
        .clk(clk), .reset_n(reset_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instruction(instruction),
        .dec_wr_en(dec_wr_en), .dec_stat_wr_en(dec_stat_wr_en), .dec_cnt_wr_en(dec_cnt_wr_en),
        .dec_add_offset(dec_add_offset), .dec_literal_adr(dec_literal_adr),
        .rf_wr_en(rf_wr_en), .stat_wr_en(stat_wr_en), .pc(pc), .busy(busy), .retired(retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // External decoder: purely a function of the instruction register.
    always_comb begin
        dec_wr_en       = (instruction[15:12] == OP_ADD);
        dec_stat_wr_en  = (instruction[15:12] == OP_ADD);
        dec_cnt_wr_en   = (instruction[15:12] == OP_GOTO) || (instruction[15:12] == OP_BRA);
        dec_add_offset  = (instruction[15:12] == OP_BRA);
        dec_literal_adr = instruction[7:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_next_pc(input logic [7:0] cur, input logic [15:0] w);
        logic [7:0] nxt;
        case (w[15:12])
            OP_GOTO: nxt = w[7:0];
            OP_BRA:  nxt = cur + w[7:0];
            default: nxt = cur + 8'd1;
        endcase
        return nxt;
    endfunction

    logic        m_busy, m_req, m_ret, m_rf, m_st;
    logic [7:0]  m_pc;
    logic [15:0] m_instr;
    int          m_left;

    // Instruction timeline: wait for ack, one settle cycle, one execute cycle, then next pc.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy <= 1'b0; m_req <= 1'b0; m_ret <= 1'b0; m_rf <= 1'b0; m_st <= 1'b0;
            m_pc <= 8'h00; m_instr <= 16'h0000; m_left <= 0;
        end else if (!m_busy) begin
            if (run) begin
                m_busy <= 1'b1;
                m_req  <= 1'b1;
            end
        end else if (m_req) begin
            if (imem_ack) begin
                m_instr <= imem_data;
                m_req   <= 1'b0;
                m_left  <= 2;
            end
        end else if (m_left == 2) begin
            m_left <= 1;
            m_ret  <= 1'b1;
            m_rf   <= (m_instr[15:12] == OP_ADD);
            m_st   <= (m_instr[15:12] == OP_ADD);
        end else begin
            m_left <= 0;
            m_ret  <= 1'b0;
            m_rf   <= 1'b0;
            m_st   <= 1'b0;
            m_pc   <= model_next_pc(m_pc, m_instr);
            if (run) m_req <= 1'b1;
            else     m_busy <= 1'b0;
        end
    end

    // Compare every cycle, half a period after the active edge.
    always @(negedge clk) begin
        chk("m_req", imem_req, m_req);
        chk("m_addr", imem_addr, m_pc);
        chk("m_pc", pc, m_pc);
        chk("m_instr", instruction, m_instr);
        chk("m_busy", busy, m_busy);
        chk("m_retired", retired, m_ret);
        chk("m_rf_wr", rf_wr_en, m_rf);
        chk("m_stat_wr", stat_wr_en, m_st);
    end

    // Memory responder: ack after ack_delay wait cycles; optional stray acks when not fetching.
    initial begin
        int wcnt;
        wcnt = 0;
        imem_ack = 1'b0;
        imem_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (reset_n && imem_req) begin
                if (wcnt >= ack_delay) begin
                    imem_ack  = 1'b1;
                    imem_data = imem[imem_addr];
                    wcnt = 0;
                end else begin
                    imem_ack  = 1'b0;
                    imem_data = 16'hBAD0;
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                imem_ack  = spurious;
                imem_data = spurious ? 16'hDEAD : 16'h0000;
            end
        end
    end

    task automatic wait_retire(output int at, output int reqc);
        reqc = 0;
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (imem_req) reqc++;
            if (retired) begin
                at = cyc;
                return;
            end
        end
        chk("retire_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    logic [7:0] exp_trace [12];
    int at, prev_at, reqc, t0;

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = {8'h00, 8'(i)};
        imem[8'h02] = 16'h1000;   // ADD
        imem[8'h05] = 16'h203F;   // GOTO 0x3F
        imem[8'h3F] = 16'h2010;   // GOTO 0x10
        imem[8'h10] = 16'h30FE;   // BRA -2 -> 0x0E
        imem[8'h0E] = 16'h20FF;   // GOTO 0xFF
        exp_trace = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                      8'h3F, 8'h10, 8'h0E, 8'hFF, 8'h00, 8'h01};

        reset_n = 1'b0;
        run = 1'b0;
        #1;
        chk("rst_pc", pc, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_retired", retired, 1'b0);
        @(negedge clk); #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_run_busy", busy, 1'b0);

        // Zero-wait program run: GOTO, relative branch back, wrap 0xFF -> 0x00.
        run = 1'b1;
        @(negedge clk);
        chk("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 8'h00);
        prev_at = -1;
        for (int k = 0; k < 12; k++) begin
            wait_retire(at, reqc);
            chk($sformatf("trace_pc%0d", k), pc, exp_trace[k]);
            chk($sformatf("trace_rf%0d", k), rf_wr_en, (exp_trace[k] == 8'h02));
            chk($sformatf("trace_st%0d", k), stat_wr_en, (exp_trace[k] == 8'h02));
            if (prev_at >= 0) chk($sformatf("spacing%0d", k), at - prev_at, 3);
            prev_at = at;
        end

        // Drop run while in DECODE: instruction still completes, then IDLE.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy && !imem_req && !retired) break;
        end
        chk("in_decode", busy && !imem_req && !retired, 1'b1);
        run = 1'b0;
        t0 = cyc;
        wait_retire(at, reqc);
        chk("rundrop_retire_lat", at - t0, 1);
        @(negedge clk);
        chk("rundrop_busy", busy, 1'b0);
        chk("rundrop_req", imem_req, 1'b0);
        repeat (2) @(negedge clk);

        // Four ack wait cycles, stray acks while not fetching.
        ack_delay = 4;
        spurious = 1'b1;
        run = 1'b1;
        wait_retire(at, reqc);
        chk("slow_req_cycles1", reqc, 5);
        prev_at = at;
        wait_retire(at, reqc);
        chk("slow_req_cycles2", reqc, 5);
        chk("slow_spacing", at - prev_at, 7);

        // Asynchronous reset in the middle of a fetch.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) break;
        end
        #2 reset_n = 1'b0;
        run = 1'b0;
        #1;
        chk("async_req", imem_req, 1'b0);
        chk("async_pc", pc, 8'h00);
        chk("async_busy", busy, 1'b0);
        chk("async_instr", instruction, 16'h0000);
        @(negedge clk); #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", busy, 1'b0);

        // Restart from 0 with immediate acks.
        ack_delay = 0;
        spurious = 1'b0;
        run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_retire(at, reqc);
            chk($sformatf("restart_pc%0d", k), pc, 8'(k));
        end
        run = 1'b0;
        repeat (4) @(negedge clk);
        chk("end_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
